// File: rtl/vga_letter_sequencer_pkg.sv
// Shared definitions for the VGA letter sequencer.
// Holds the letter code type and constants (A..Y, BLANK), the fixed port
// widths of the sequencer bus, the sequencer state encodings and the
// theme encodings.
package vga_letter_pkg;

    typedef logic [4:0] letter_t;

    localparam letter_t LETTER_A = 5'd0,  LETTER_B = 5'd1,  LETTER_C = 5'd2;
    localparam letter_t LETTER_D = 5'd3,  LETTER_E = 5'd4,  LETTER_F = 5'd5;
    localparam letter_t LETTER_G = 5'd6,  LETTER_H = 5'd7,  LETTER_I = 5'd8;
    localparam letter_t LETTER_J = 5'd9,  LETTER_K = 5'd10, LETTER_L = 5'd11;
    localparam letter_t LETTER_M = 5'd12, LETTER_N = 5'd13, LETTER_O = 5'd14;
    localparam letter_t LETTER_P = 5'd15, LETTER_Q = 5'd16, LETTER_R = 5'd17;
    localparam letter_t LETTER_S = 5'd18, LETTER_T = 5'd19, LETTER_U = 5'd20;
    localparam letter_t LETTER_V = 5'd21, LETTER_W = 5'd22, LETTER_X = 5'd23;
    localparam letter_t LETTER_Y = 5'd24;
    localparam letter_t LETTER_BLANK = 5'd31;

    // Bus widths: 16-entry buffer address, 4 visible slots, 5-bit length.
    localparam int ADDR_W = 4;
    localparam int SLOT_W = 2;
    localparam int LEN_W  = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHOW   = 2'd1,
        ST_SCROLL = 2'd2
    } seq_state_e;

    localparam logic THEME_DARK  = 1'b0;
    localparam logic THEME_LIGHT = 1'b1;

endpackage

// File: rtl/vga_letter_sequencer_if.sv
// Bus between the host/renderer and the letter sequencer.
// master: host side (drives writes, control pulses, frame tick, slot query).
// slave : sequencer side (returns letter, theme, busy, offset, wr_reject).
interface vga_letter_sequencer_if;
    import vga_letter_pkg::*;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    letter_t           wr_letter;
    logic              wr_reject;
    logic [LEN_W-1:0]  msg_len;
    logic              start;
    logic              stop;
    logic              scroll_en;
    logic              theme_tgl;
    logic              frame_tick;
    logic [SLOT_W-1:0] slot_idx;
    letter_t           letter;
    logic              theme;
    logic              busy;
    logic [4:0]        offset;

    modport master (
        output wr_en, wr_addr, wr_letter, msg_len, start, stop, scroll_en,
               theme_tgl, frame_tick, slot_idx,
        input  wr_reject, letter, theme, busy, offset
    );

    modport slave (
        input  wr_en, wr_addr, wr_letter, msg_len, start, stop, scroll_en,
               theme_tgl, frame_tick, slot_idx,
        output wr_reject, letter, theme, busy, offset
    );

endinterface

// File: rtl/vga_letter_sequencer_msg_ram.sv
// vga_msg_ram: DEPTH x 5-bit message register file.
// Ports: clk (write clock), wr_en_i/wr_addr_i/wr_data_i (sync write port),
//        rd_addr_i/rd_data_o (async read port).
// Contents are deliberately not reset; the caller guarantees addresses < DEPTH.
module vga_msg_ram
    import vga_letter_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  letter_t       wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output letter_t       rd_data_o
);

    letter_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/vga_letter_sequencer.sv
// vga_letter_sequencer: puts a stored message onto WIN on-screen letter slots,
// static or scrolling one letter per FRAMES_PER_STEP frame ticks, and owns
// the 1-bit colour theme.
// Ports: clk, rst (async, active high), bus (slave side of
//        vga_letter_sequencer_if: write port, control pulses, frame tick,
//        slot query in; letter, theme, busy, offset, wr_reject out).
module vga_letter_sequencer
    import vga_letter_pkg::*;
#(
    parameter int MSG_LEN         = 16,
    parameter int WIN             = 4,
    parameter int FRAMES_PER_STEP = 30
) (
    input  logic                   clk,
    input  logic                   rst,
    vga_letter_sequencer_if.slave  bus
);

    localparam logic [5:0] MSG_LEN6 = 6'(MSG_LEN);
    localparam logic [5:0] WIN6     = 6'(WIN);
    localparam logic [5:0] FPS_LAST = 6'(FRAMES_PER_STEP - 1);

    seq_state_e        state_q, state_d;
    logic [4:0]        offset_q, offset_d;
    logic [5:0]        counter_q, counter_d;
    logic [4:0]        len_q, len_d;
    letter_t           letter_q, letter_d;
    logic              theme_q, theme_d;
    logic              wr_reject_q, wr_reject_d;

    logic              wr_ok;
    logic              start_ok;
    logic [5:0]        cycle_len;   // L = len + 1, one BLANK gap before wrap
    logic [5:0]        slot6;
    logic [5:0]        offset_inc;
    logic [5:0]        p;
    logic [ADDR_W-1:0] rd_addr;
    letter_t           rd_data;

    assign slot6      = {{(6-SLOT_W){1'b0}}, bus.slot_idx};
    assign cycle_len  = {1'b0, len_q} + 6'd1;
    assign offset_inc = {1'b0, offset_q} + 6'd1;
    assign wr_ok      = bus.wr_en && (state_q == ST_IDLE)
                        && ({{(6-ADDR_W){1'b0}}, bus.wr_addr} < MSG_LEN6);
    assign start_ok   = bus.start && (bus.msg_len != '0)
                        && ({1'b0, bus.msg_len} <= MSG_LEN6);

    // Scroll position p = (offset + slot) mod L. The sum is below L + WIN,
    // so WIN conditional subtractions give a true modulo even when L < WIN.
    always_comb begin
        p = {1'b0, offset_q} + slot6;
        for (int i = 0; i < WIN; i++) begin
            if (p >= cycle_len) begin
                p = p - cycle_len;
            end
        end
    end

    assign rd_addr = (state_q == ST_SCROLL) ? p[ADDR_W-1:0]
                                            : {{(ADDR_W-SLOT_W){1'b0}}, bus.slot_idx};

    vga_msg_ram #(
        .DEPTH (MSG_LEN),
        .AW    (ADDR_W)
    ) u_msg_ram (
        .clk       (clk),
        .wr_en_i   (wr_ok),
        .wr_addr_i (bus.wr_addr),
        .wr_data_i (bus.wr_letter),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    always_comb begin
        state_d     = state_q;
        offset_d    = offset_q;
        counter_d   = counter_q;
        len_d       = len_q;
        letter_d    = LETTER_BLANK;
        theme_d     = theme_q ^ bus.theme_tgl;
        wr_reject_d = bus.wr_en && !wr_ok;

        // Read path: p == len is the gap slot, so p >= len means BLANK.
        if (slot6 < WIN6) begin
            if (state_q == ST_SHOW && slot6 < {1'b0, len_q}) begin
                letter_d = rd_data;
            end else if (state_q == ST_SCROLL && p < {1'b0, len_q}) begin
                letter_d = rd_data;
            end
        end

        if (bus.stop) begin
            state_d   = ST_IDLE;
            offset_d  = '0;
            counter_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_ok) begin
                        state_d   = bus.scroll_en ? ST_SCROLL : ST_SHOW;
                        len_d     = bus.msg_len;
                        offset_d  = '0;
                        counter_d = '0;
                    end
                end
                ST_SHOW: begin
                    if (bus.scroll_en) begin
                        state_d   = ST_SCROLL;
                        counter_d = '0;
                    end
                end
                ST_SCROLL: begin
                    if (!bus.scroll_en) begin
                        state_d = ST_SHOW;
                    end else if (bus.frame_tick) begin
                        if (counter_q == FPS_LAST) begin
                            counter_d = '0;
                            offset_d  = (offset_inc == cycle_len) ? 5'd0 : offset_inc[4:0];
                        end else begin
                            counter_d = counter_q + 6'd1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            offset_q    <= '0;
            counter_q   <= '0;
            len_q       <= '0;
            letter_q    <= LETTER_BLANK;
            theme_q     <= THEME_DARK;
            wr_reject_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            offset_q    <= offset_d;
            counter_q   <= counter_d;
            len_q       <= len_d;
            letter_q    <= letter_d;
            theme_q     <= theme_d;
            wr_reject_q <= wr_reject_d;
        end
    end

    assign bus.letter    = letter_q;
    assign bus.theme     = theme_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.offset    = offset_q;
    assign bus.wr_reject = wr_reject_q;

endmodule
